// File: rtl/adc_model_pkg.sv
// Shared types and sizing helpers for the serial SAR ADC behavioural model.
package adc_model_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    READ = 2'd2,
    DONE = 2'd3
  } state_e;

  // Smallest legal conversion time: the synchroniser, the load and the
  // READ hand-over all need a cycle.
  localparam int unsigned MIN_CONV_CYCLES = 4;

  // Bits shifted per frame: every channel plus the optional leading busy bit.
  function automatic int unsigned frame_bits(input int unsigned data_bits,
                                             input int unsigned num_ch,
                                             input int unsigned busy_ind);
    return num_ch * data_bits + busy_ind;
  endfunction

  // Width of a counter that must hold values 0..max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser for an asynchronous pin, followed by registered
// single-cycle rise/fall pulses. A pin edge shows up as a pulse on the
// third SYSCLK edge after it.
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  // Next values: shift the pin through the chain and compare the last two taps.
  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    meta_d = din;
    sync_d = meta_q;
    prev_d = sync_q;
    rise_d = sync_q & ~prev_q;
    fall_d = ~sync_q & prev_q;
  end

  // Synchroniser and pulse registers, cleared by reset.
  // NOTE: flops use non-blocking assignments so all stages update together on the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/adc_serial_model.sv
// Behavioural SAR ADC with CNVST/SCLK/SDOUT serial interface. All host pins
// are sampled on SYSCLK; NUM_CH daisy-chained channels are shifted MSB first,
// channel 0 first, optionally preceded by a busy bit.
module adc_serial_model
  import adc_model_pkg::*;
#(
  parameter int unsigned DATA_BITS   = 16,
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned CONV_CYCLES = 140,
  parameter int unsigned BUSY_IND    = 1,
  parameter logic [15:0] SEED        = 16'hABCD,
  parameter logic [15:0] CH_OFFSET   = 16'h1000,
  parameter int unsigned STEP        = 1
) (
  input  logic        SYSCLK,
  input  logic        RESET,
  input  logic        AD_SCLK,
  input  logic        AD_CNVST,
  output logic        AD_SDOUT,
  input  logic        PAT_MODE,
  input  logic        CLR_FLAGS,
  output logic        FRAME_DONE,
  output logic        CONV_VIOL,
  output logic        SCLK_VIOL,
  output logic        READ_ABORT,
  output logic [15:0] FRAME_CNT
);

  localparam int unsigned DATA_W     = NUM_CH * DATA_BITS;
  localparam int unsigned FRAME_BITS = frame_bits(DATA_BITS, NUM_CH, BUSY_IND);
  localparam int unsigned CONV_W     = cnt_width(CONV_CYCLES - 1);
  localparam int unsigned BIT_W      = cnt_width(FRAME_BITS);

  localparam logic [CONV_W-1:0] CONV_LOAD  = CONV_W'(CONV_CYCLES - 1);
  localparam logic [CONV_W-1:0] CONV_LAST  = CONV_W'(1);
  localparam logic [BIT_W-1:0]  BIT_END    = BIT_W'(FRAME_BITS);
  localparam logic [DATA_BITS-1:0] STEP_W  = DATA_BITS'(STEP);

  // Reset value of channel k: SEED + k*CH_OFFSET, wrapped to DATA_BITS.
  function automatic logic [DATA_BITS-1:0] ch_seed(input int k);
    logic [31:0] sum;
    sum = 32'(SEED) + 32'(k) * 32'(CH_OFFSET);
    return sum[DATA_BITS-1:0];
  endfunction

  logic sclk_rise, sclk_fall;
  logic cnvst_rise;
  logic cnvst_fall_unused;  // CNVST falling edges carry no meaning for this model

  sync_edge_det u_sclk_sync (
    .clk  (SYSCLK),
    .rst  (RESET),
    .din  (AD_SCLK),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  sync_edge_det u_cnvst_sync (
    .clk  (SYSCLK),
    .rst  (RESET),
    .din  (AD_CNVST),
    .rise (cnvst_rise),
    .fall (cnvst_fall_unused)
  );

  state_e              state_q, state_d;
  logic [CONV_W-1:0]   conv_cnt_q, conv_cnt_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic                sdout_q, sdout_d;
  logic                frame_done_q, frame_done_d;
  logic                read_abort_q, read_abort_d;
  logic                conv_viol_q, conv_viol_d;
  logic                sclk_viol_q, sclk_viol_d;
  logic [15:0]         frame_cnt_q, frame_cnt_d;
  logic [DATA_BITS-1:0] ch_q [NUM_CH];
  logic [DATA_BITS-1:0] ch_d [NUM_CH];
  logic [DATA_W-1:0]   snap;

  // Frame image of the current channel values, channel 0 in the MSBs.
  always_comb begin
    snap = '0;
    for (int k = 0; k < int'(NUM_CH); k++) begin
      snap[DATA_W-1-k*DATA_BITS -: DATA_BITS] = ch_q[k];
    end
  end

  // State register and all datapath flops.
  // NOTE: the channel registers are reset because they define the data pattern the bench expects.
  always_ff @(posedge SYSCLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= IDLE;
      conv_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shreg_q      <= '1;
      sdout_q      <= 1'b1;
      frame_done_q <= 1'b0;
      read_abort_q <= 1'b0;
      conv_viol_q  <= 1'b0;
      sclk_viol_q  <= 1'b0;
      frame_cnt_q  <= '0;
      for (int k = 0; k < int'(NUM_CH); k++) begin
        ch_q[k] <= ch_seed(k);
      end
    end else begin
      state_q      <= state_d;
      conv_cnt_q   <= conv_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      sdout_q      <= sdout_d;
      frame_done_q <= frame_done_d;
      read_abort_q <= read_abort_d;
      conv_viol_q  <= conv_viol_d;
      sclk_viol_q  <= sclk_viol_d;
      frame_cnt_q  <= frame_cnt_d;
      ch_q         <= ch_d;
    end
  end

  // Next-state logic. CONV is left on the edge where the counter reaches
  // zero; a CNVST rise in READ beats any SCLK activity.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (cnvst_rise) state_d = CONV;
      CONV: if (conv_cnt_q == CONV_LAST) state_d = READ;
      READ: begin
        if (cnvst_rise)                state_d = CONV;
        else if (bit_cnt_q == BIT_END) state_d = DONE;
      end
      DONE: state_d = IDLE;
    endcase
  end

  // Datapath and output values for each state.
  always_comb begin
    conv_cnt_d   = conv_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    sdout_d      = sdout_q;
    frame_done_d = 1'b0;
    read_abort_d = 1'b0;
    conv_viol_d  = conv_viol_q & ~CLR_FLAGS;
    sclk_viol_d  = sclk_viol_q & ~CLR_FLAGS;
    frame_cnt_d  = frame_cnt_q;
    ch_d         = ch_q;

    unique case (state_q)
      IDLE: begin
        sdout_d = 1'b1;
        if (cnvst_rise) begin
          conv_cnt_d = CONV_LOAD;
          shreg_d    = snap;
        end
      end

      CONV: begin
        sdout_d    = 1'b1;
        conv_cnt_d = conv_cnt_q - 1'b1;
        // Violations are only flagged; the conversion carries on untouched.
        if (cnvst_rise) conv_viol_d = 1'b1;
        if (sclk_rise)  sclk_viol_d = 1'b1;
        if (conv_cnt_q == CONV_LAST) begin
          bit_cnt_d = '0;
          if (BUSY_IND != 0) begin
            sdout_d = 1'b0;
          end else begin
            sdout_d = shreg_q[DATA_W-1];
            shreg_d = {shreg_q[DATA_W-2:0], 1'b1};
          end
        end
      end

      READ: begin
        if (cnvst_rise) begin
          // Restart: fresh snapshot, channel values left as they were.
          sdout_d      = 1'b1;
          conv_cnt_d   = CONV_LOAD;
          shreg_d      = snap;
          read_abort_d = 1'b1;
        end else if (bit_cnt_q == BIT_END) begin
          // Last bit taken; late SCLK falls no longer reach AD_SDOUT.
          sdout_d      = 1'b1;
          frame_done_d = 1'b1;
          frame_cnt_d  = frame_cnt_q + 16'd1;
          if (!PAT_MODE) begin
            for (int k = 0; k < int'(NUM_CH); k++) begin
              ch_d[k] = ch_q[k] + STEP_W;
            end
          end
        end else begin
          if (sclk_rise) bit_cnt_d = bit_cnt_q + 1'b1;
          if (sclk_fall) begin
            sdout_d = shreg_q[DATA_W-1];
            shreg_d = {shreg_q[DATA_W-2:0], 1'b1};
          end
        end
      end

      DONE: sdout_d = 1'b1;
    endcase
  end

  assign AD_SDOUT   = sdout_q;
  assign FRAME_DONE = frame_done_q;
  assign READ_ABORT = read_abort_q;
  assign CONV_VIOL  = conv_viol_q;
  assign SCLK_VIOL  = sclk_viol_q;
  assign FRAME_CNT  = frame_cnt_q;

endmodule

// File: tb/tb_adc_serial_model.sv
// Bench for adc_serial_model: three instances (defaults, no busy bit,
// single wrapping channel) driven by a host model with 80 ns SCLK.
module tb_adc_serial_model;

  logic        clk;
  logic [2:0]  rst;
  logic [2:0]  sclk;
  logic [2:0]  cnvst;
  logic        pat_mode;
  logic        clr_flags;
  logic [2:0]  sdout;
  logic [2:0]  frame_done;
  logic [2:0]  conv_viol;
  logic [2:0]  sclk_viol;
  logic [2:0]  read_abort;
  logic [15:0] fcnt [3];

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt [3] = '{0, 0, 0};
  int abort_cnt [3] = '{0, 0, 0};

  adc_serial_model u0 (
    .SYSCLK(clk), .RESET(rst[0]), .AD_SCLK(sclk[0]), .AD_CNVST(cnvst[0]),
    .AD_SDOUT(sdout[0]), .PAT_MODE(pat_mode), .CLR_FLAGS(clr_flags),
    .FRAME_DONE(frame_done[0]), .CONV_VIOL(conv_viol[0]), .SCLK_VIOL(sclk_viol[0]),
    .READ_ABORT(read_abort[0]), .FRAME_CNT(fcnt[0])
  );

  adc_serial_model #(.BUSY_IND(0)) u1 (
    .SYSCLK(clk), .RESET(rst[1]), .AD_SCLK(sclk[1]), .AD_CNVST(cnvst[1]),
    .AD_SDOUT(sdout[1]), .PAT_MODE(pat_mode), .CLR_FLAGS(clr_flags),
    .FRAME_DONE(frame_done[1]), .CONV_VIOL(conv_viol[1]), .SCLK_VIOL(sclk_viol[1]),
    .READ_ABORT(read_abort[1]), .FRAME_CNT(fcnt[1])
  );

  adc_serial_model #(.SEED(16'hFFFF), .NUM_CH(1)) u2 (
    .SYSCLK(clk), .RESET(rst[2]), .AD_SCLK(sclk[2]), .AD_CNVST(cnvst[2]),
    .AD_SDOUT(sdout[2]), .PAT_MODE(pat_mode), .CLR_FLAGS(clr_flags),
    .FRAME_DONE(frame_done[2]), .CONV_VIOL(conv_viol[2]), .SCLK_VIOL(sclk_viol[2]),
    .READ_ABORT(read_abort[2]), .FRAME_CNT(fcnt[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one-cycle pulses per instance.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (frame_done[i] === 1'b1) done_cnt[i]++;
      if (read_abort[i] === 1'b1) abort_cnt[i]++;
    end
  end

  // Hard stop if something hangs.
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // CNVST pulse followed by 200 cycles; optional extra CNVST/SCLK/CLR_FLAGS
  // pulses at given cycle numbers. lat = first cycle SDOUT reads 0 (0 if never).
  task automatic conv(input int idx, input int cnv_at, input int sclk_at,
                      input int clr_at, output int lat);
    cnvst[idx] = 1'b1;
    lat = 0;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk);
      #1;
      if (n == 5)           cnvst[idx] = 1'b0;
      if (n == cnv_at)      cnvst[idx] = 1'b1;
      if (n == cnv_at + 5)  cnvst[idx] = 1'b0;
      if (n == sclk_at)     sclk[idx]  = 1'b1;
      if (n == sclk_at + 4) sclk[idx]  = 1'b0;
      if (n == clr_at)      clr_flags  = 1'b1;
      if (n == clr_at + 1)  clr_flags  = 1'b0;
      if (lat == 0 && n > 10 && sdout[idx] === 1'b0) lat = n;
    end
  endtask

  // Host read: sample SDOUT at each SCLK rise, 40 ns high / 40 ns low.
  task automatic read_bits(input int idx, input int nbits, output logic [63:0] v);
    v = '0;
    for (int i = 0; i < nbits; i++) begin
      v = {v[62:0], sdout[idx]};
      sclk[idx] = 1'b1;
      cyc(4);
      sclk[idx] = 1'b0;
      cyc(4);
    end
    cyc(4);
  endtask

  typedef struct {
    int          idx;
    int          nbits;
    logic        pat;
    logic [63:0] exp_data;
    logic [15:0] exp_cnt;
    int          exp_lat;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic [63:0] v;
    int lat;
    int d0, a0;

    vecs[0] = '{0, 33, 1'b0, 64'h0_ABCD_BBCD, 16'd1, 143};
    vecs[1] = '{0, 33, 1'b1, 64'h0_ABCE_BBCE, 16'd2, 143};
    vecs[2] = '{0, 33, 1'b1, 64'h0_ABCE_BBCE, 16'd3, 143};
    vecs[3] = '{1, 32, 1'b0, 64'hABCD_BBCD,   16'd1, 0};
    vecs[4] = '{2, 17, 1'b0, 64'h0_FFFF,      16'd1, 143};
    vecs[5] = '{2, 17, 1'b0, 64'h0_0000,      16'd2, 143};

    rst = 3'b111; sclk = '0; cnvst = '0; pat_mode = 1'b0; clr_flags = 1'b0;
    cyc(3);
    check("reset sdout",      64'(sdout),      64'h7);
    check("reset frame_done", 64'(frame_done), 64'h0);
    rst = 3'b000;
    cyc(3);
    check("idle sdout",       64'(sdout),      64'h7);
    check("reset conv_viol",  64'(conv_viol),  64'h0);
    check("reset sclk_viol",  64'(sclk_viol),  64'h0);
    check("reset read_abort", 64'(read_abort), 64'h0);
    check("reset frame_cnt",  64'(fcnt[0]),    64'h0);

    for (int i = 0; i < 6; i++) begin
      pat_mode = vecs[i].pat;
      d0 = done_cnt[vecs[i].idx];
      conv(vecs[i].idx, -100, -100, -100, lat);
      check($sformatf("vec%0d latency", i), 64'(lat), 64'(vecs[i].exp_lat));
      read_bits(vecs[i].idx, vecs[i].nbits, v);
      check($sformatf("vec%0d data", i), v, vecs[i].exp_data);
      check($sformatf("vec%0d frame_cnt", i), 64'(fcnt[vecs[i].idx]), 64'(vecs[i].exp_cnt));
      check($sformatf("vec%0d frame_done pulses", i), 64'(done_cnt[vecs[i].idx] - d0), 64'd1);
    end

    // Violations during CONV; READ timing must be unaffected.
    pat_mode = 1'b1;
    conv(0, 50, 80, -100, lat);
    check("viol latency",   64'(lat),          64'd143);
    check("viol conv_viol", 64'(conv_viol[0]), 64'd1);
    check("viol sclk_viol", 64'(sclk_viol[0]), 64'd1);
    read_bits(0, 33, v);
    check("viol data",      v,                 64'h0_ABCE_BBCE);
    check("viol frame_cnt", 64'(fcnt[0]),      64'd4);
    clr_flags = 1'b1;
    cyc(1);
    clr_flags = 1'b0;
    cyc(1);
    check("clr conv_viol",  64'(conv_viol[0]), 64'd0);
    check("clr sclk_viol",  64'(sclk_viol[0]), 64'd0);

    // CLR_FLAGS in the same cycle as a new violation: the set wins.
    conv(0, 50, -100, 53, lat);
    check("setwins conv_viol", 64'(conv_viol[0]), 64'd1);
    check("setwins sclk_viol", 64'(sclk_viol[0]), 64'd0);
    read_bits(0, 33, v);
    check("setwins frame_cnt", 64'(fcnt[0]), 64'd5);
    clr_flags = 1'b1;
    cyc(1);
    clr_flags = 1'b0;

    // Reset in the middle of a frame.
    conv(0, -100, -100, -100, lat);
    read_bits(0, 10, v);
    rst[0] = 1'b1;
    #1;
    check("midreset sdout",     64'(sdout[0]),     64'd1);
    check("midreset frame_cnt", 64'(fcnt[0]),      64'd0);
    check("midreset conv_viol", 64'(conv_viol[0]), 64'd0);
    cyc(2);
    rst[0] = 1'b0;
    cyc(3);
    conv(0, -100, -100, -100, lat);
    read_bits(0, 33, v);
    check("post reset data",      v,            64'h0_ABCD_BBCD);
    check("post reset frame_cnt", 64'(fcnt[0]), 64'd1);

    // Abort after 10 bits, then a clean re-read of the same values.
    conv(0, -100, -100, -100, lat);
    read_bits(0, 10, v);
    d0 = done_cnt[0];
    a0 = abort_cnt[0];
    conv(0, -100, -100, -100, lat);
    check("abort pulse",      64'(abort_cnt[0] - a0), 64'd1);
    check("abort no done",    64'(done_cnt[0] - d0),  64'd0);
    check("abort latency",    64'(lat),               64'd143);
    read_bits(0, 33, v);
    check("abort reread",     v,                      64'h0_ABCD_BBCD);
    check("abort frame_cnt",  64'(fcnt[0]),           64'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
